// File: rtl/axi_lite_slave_bridge.sv
// AXI4-Lite slave front end driving the accelerator's flat single-cycle register/BRAM bus.
// Optional AXI_BRIDGE_SLVERR_EN: out-of-range or misaligned accesses get SLVERR with no core pulse.
module axi_lite_slave_bridge #(
  parameter int ADDR_WIDTH = 20,
  parameter int RD_LATENCY = 1,
  parameter int HIGH_ADDR  = 547922
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [31:0]           s_wdata,
  input  logic [3:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [31:0]           s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  axi_wr_en,
  output logic [ADDR_WIDTH-1:0] axi_wr_addr,
  output logic [31:0]           axi_wr_data,
  output logic [3:0]            axi_wr_strobe,
  output logic                  axi_rd_en,
  output logic [ADDR_WIDTH-1:0] axi_rd_addr,
  input  logic [31:0]           axi_rd_data
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [2:0]          RD_LAT     = 3'(RD_LATENCY);
  localparam logic [ADDR_WIDTH:0] HIGH_LIMIT = (ADDR_WIDTH + 1)'(HIGH_ADDR);

`ifdef AXI_BRIDGE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    return SLVERR_EN && (({1'b0, a} >= HIGH_LIMIT) || (a[1:0] != 2'b00));
  endfunction

  // ---------------- write path ----------------
  logic                  aw_full_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic                  w_full_reg;
  logic [31:0]           w_data_reg;
  logic [3:0]            w_strb_reg;
  logic                  wr_busy_reg;
  logic                  wr_err_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  wr_issue;
  logic                  wr_err_now;
  logic [ADDR_WIDTH-1:0] aw_addr_sel;
  logic [31:0]           w_data_sel;
  logic [3:0]            w_strb_sel;

  assign s_awready = ~aw_full_reg;
  assign s_wready  = ~w_full_reg;
  assign aw_hs     = s_awvalid & ~aw_full_reg;
  assign w_hs      = s_wvalid & ~w_full_reg;

  // Bypass the holding registers so a same-cycle AW+W pair issues on the very next cycle.
  assign aw_addr_sel = aw_full_reg ? aw_addr_reg : s_awaddr;
  assign w_data_sel  = w_full_reg ? w_data_reg : s_wdata;
  assign w_strb_sel  = w_full_reg ? w_strb_reg : s_wstrb;
  assign wr_issue    = (aw_full_reg | aw_hs) & (w_full_reg | w_hs) & ~s_bvalid & ~wr_busy_reg;
  assign wr_err_now  = addr_bad(aw_addr_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_reg   <= 1'b0;
      aw_addr_reg   <= '0;
      w_full_reg    <= 1'b0;
      w_data_reg    <= '0;
      w_strb_reg    <= '0;
      wr_busy_reg   <= 1'b0;
      wr_err_reg    <= 1'b0;
      axi_wr_en     <= 1'b0;
      axi_wr_addr   <= '0;
      axi_wr_data   <= '0;
      axi_wr_strobe <= '0;
      s_bvalid      <= 1'b0;
      s_bresp       <= 2'b00;
    end else begin
      if (wr_issue) begin
        aw_full_reg <= 1'b0;
      end else if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= s_awaddr;
      end

      if (wr_issue) begin
        w_full_reg <= 1'b0;
      end else if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= s_wdata;
        w_strb_reg <= s_wstrb;
      end

      // wr_busy_reg tracks the issue slot even when the core pulse is suppressed,
      // so error responses keep normal timing.
      wr_busy_reg <= wr_issue;
      axi_wr_en   <= wr_issue & ~wr_err_now;
      if (wr_issue) begin
        axi_wr_addr   <= aw_addr_sel;
        axi_wr_data   <= w_data_sel;
        axi_wr_strobe <= w_strb_sel;
        wr_err_reg    <= wr_err_now;
      end

      if (wr_busy_reg) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_err_reg ? 2'b10 : 2'b00;
      end else if (s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // ---------------- read path ----------------
  logic [1:0] rd_state_reg;
  logic [2:0] rd_cnt_reg;
  logic       rd_err_reg;
  logic       ar_hs;

  assign s_arready = (rd_state_reg == R_IDLE);
  assign ar_hs     = s_arvalid & s_arready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_reg <= R_IDLE;
      rd_cnt_reg   <= '0;
      rd_err_reg   <= 1'b0;
      axi_rd_en    <= 1'b0;
      axi_rd_addr  <= '0;
      s_rvalid     <= 1'b0;
      s_rdata      <= '0;
      s_rresp      <= 2'b00;
    end else begin
      axi_rd_en <= 1'b0;
      case (rd_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            // axi_rd_addr only ever changes here, so combinational core reads stay stable.
            axi_rd_addr  <= s_araddr;
            rd_err_reg   <= addr_bad(s_araddr);
            axi_rd_en    <= ~addr_bad(s_araddr);
            rd_cnt_reg   <= RD_LAT;
            rd_state_reg <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_cnt_reg == 3'd0) begin
            s_rdata      <= rd_err_reg ? 32'h0 : axi_rd_data;
            s_rresp      <= rd_err_reg ? 2'b10 : 2'b00;
            s_rvalid     <= 1'b1;
            rd_state_reg <= R_RESP;
          end else begin
            rd_cnt_reg <= rd_cnt_reg - 3'd1;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid     <= 1'b0;
            rd_state_reg <= R_IDLE;
          end
        end
        default: rd_state_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// Self-checking bench for axi_lite_slave_bridge: directed timing cases plus randomized
// AXI-Lite traffic against a word-array memory model; honours AXI_BRIDGE_SLVERR_EN.
module tb_axi_lite_slave_bridge;
  localparam int AW  = 20;
  localparam int LAT = 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] s_awaddr;
  logic          s_awvalid;
  logic          s_awready;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  logic          s_wvalid;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid;
  logic          s_arready;
  logic [31:0]   s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready;
  logic          axi_wr_en;
  logic [AW-1:0] axi_wr_addr;
  logic [31:0]   axi_wr_data;
  logic [3:0]    axi_wr_strobe;
  logic          axi_rd_en;
  logic [AW-1:0] axi_rd_addr;
  logic [31:0]   axi_rd_data;

  axi_lite_slave_bridge #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT), .HIGH_ADDR(547922)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
    .axi_wr_strobe(axi_wr_strobe), .axi_rd_en(axi_rd_en), .axi_rd_addr(axi_rd_addr),
    .axi_rd_data(axi_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit exp_err(input logic [AW-1:0] a);
`ifdef AXI_BRIDGE_SLVERR_EN
    return (int'(a) >= 547922) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Core-side memory: 64 words, indexed by byte address bits [7:2], reloaded on reset.
  logic [31:0] core_mem [0:63];
  logic [31:0] ref_mem  [0:63];
  assign axi_rd_data = core_mem[axi_rd_addr[7:2]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) core_mem[i] <= init_val(i);
    end else if (axi_wr_en) begin
      core_mem[axi_wr_addr[7:2]] <= merge(core_mem[axi_wr_addr[7:2]], axi_wr_data, axi_wr_strobe);
    end
  end

  int          wr_pulses = 0;
  int          rd_pulses = 0;
  logic [AW-1:0] wr_last_addr;
  logic [31:0] wr_last_data;
  logic [3:0]  wr_last_strb;
  logic [AW-1:0] rd_last_addr;

  always @(negedge clk) begin
    if (axi_wr_en) begin
      wr_pulses    = wr_pulses + 1;
      wr_last_addr = axi_wr_addr;
      wr_last_data = axi_wr_data;
      wr_last_strb = axi_wr_strobe;
    end
    if (axi_rd_en) begin
      rd_pulses    = rd_pulses + 1;
      rd_last_addr = axi_rd_addr;
    end
  end

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!exp_err(a)) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    int p0;
    bit e;
    p0 = wr_pulses;
    e  = exp_err(a);
    ref_write(a, d, s);
    fork
      begin
        int n;
        repeat (aw_dly) @(negedge clk);
        s_awaddr = a; s_awvalid = 1'b1; n = 0;
        while (!s_awready && n < 200) begin @(negedge clk); n++; end
        check("aw_accept", s_awready, 1'b1);
        @(negedge clk);
        s_awvalid = 1'b0;
      end
      begin
        int n;
        repeat (w_dly) @(negedge clk);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1; n = 0;
        while (!s_wready && n < 200) begin @(negedge clk); n++; end
        check("w_accept", s_wready, 1'b1);
        @(negedge clk);
        s_wvalid = 1'b0;
      end
      begin
        int n;
        n = 0;
        while (!s_bvalid && n < 200) begin @(negedge clk); n++; end
        check("bvalid_seen", s_bvalid, 1'b1);
        repeat (b_dly) @(negedge clk);
        check("bresp", s_bresp, e ? 2'b10 : 2'b00);
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
      end
    join
    check("wr_pulse_count", wr_pulses - p0, e ? 0 : 1);
    if (!e) begin
      check("wr_addr", wr_last_addr, a);
      check("wr_data", wr_last_data, d);
      check("wr_strb", wr_last_strb, s);
    end
    $display("write addr=0x%05h data=0x%08h strb=0x%0h err=%0d", a, d, s, e);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly);
    int p0;
    bit e;
    logic [31:0] exp_d;
    p0    = rd_pulses;
    e     = exp_err(a);
    exp_d = e ? 32'h0 : ref_mem[a[7:2]];
    begin
      int n;
      repeat (ar_dly) @(negedge clk);
      s_araddr = a; s_arvalid = 1'b1; n = 0;
      while (!s_arready && n < 200) begin @(negedge clk); n++; end
      check("ar_accept", s_arready, 1'b1);
      @(negedge clk);
      s_arvalid = 1'b0;
      n = 0;
      while (!s_rvalid && n < 200) begin @(negedge clk); n++; end
      check("rvalid_seen", s_rvalid, 1'b1);
      repeat (r_dly) @(negedge clk);
      check("rdata", s_rdata, exp_d);
      check("rresp", s_rresp, e ? 2'b10 : 2'b00);
      s_rready = 1'b1;
      @(negedge clk);
      s_rready = 1'b0;
    end
    check("rd_pulse_count", rd_pulses - p0, e ? 0 : 1);
    if (!e) check("rd_addr", rd_last_addr, a);
    $display("read  addr=0x%05h data=0x%08h err=%0d", a, exp_d, e);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = 20'h60800 | AW'($urandom_range(0, 63) << 2);
`ifdef AXI_BRIDGE_SLVERR_EN
    case ($urandom_range(0, 7))
      0: a = 20'h86000 | AW'($urandom_range(0, 63) << 2);
      1: a = a | 20'h2;
      default: ;
    endcase
`endif
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int p0;
    logic [AW-1:0] wa, ra;
    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_awready", s_awready, 1'b1);
    check("rst_wready", s_wready, 1'b1);
    check("rst_arready", s_arready, 1'b1);
    check("rst_bvalid", s_bvalid, 1'b0);
    check("rst_rvalid", s_rvalid, 1'b0);
    check("rst_wr_en", axi_wr_en, 1'b0);
    check("rst_rd_en", axi_rd_en, 1'b0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_wr_addr", axi_wr_addr, 20'h0);

    // same-cycle AW+W, exact cycle timing
    p0 = wr_pulses;
    s_awaddr = 20'h60808; s_awvalid = 1'b1;
    s_wdata = 32'h1; s_wstrb = 4'h1; s_wvalid = 1'b1; s_bready = 1'b1;
    ref_write(20'h60808, 32'h1, 4'h1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("d1_wr_en_t1", axi_wr_en, 1'b1);
    check("d1_wr_addr", axi_wr_addr, 20'h60808);
    check("d1_wr_data", axi_wr_data, 32'h1);
    check("d1_wr_strb", axi_wr_strobe, 4'h1);
    check("d1_bvalid_t1", s_bvalid, 1'b0);
    @(negedge clk);
    check("d1_wr_en_t2", axi_wr_en, 1'b0);
    check("d1_bvalid_t2", s_bvalid, 1'b1);
    check("d1_bresp", s_bresp, 2'b00);
    @(negedge clk);
    check("d1_bvalid_t3", s_bvalid, 1'b0);
    check("d1_pulses", wr_pulses - p0, 1);
    s_bready = 1'b0;
    $display("write addr=0x60808 data=0x00000001 strb=0x1 timing");

    // W first, AW three cycles later: nothing issued before AW
    p0 = wr_pulses;
    fork
      do_write(20'h6080C, 32'hA5A5_0001, 4'hF, 3, 0, 0);
      begin
        repeat (3) @(negedge clk);
        #1;
        check("d2_no_early_wr", wr_pulses - p0, 0);
        check("d2_wready_held", s_wready, 1'b0);
        check("d2_awready", s_awready, 1'b1);
      end
    join

    // read latency and address stability (core word 1 set to 0x1 first)
    do_write(20'h60804, 32'h1, 4'hF, 0, 0, 0);
    s_araddr = 20'h60804; s_arvalid = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    check("d3_rd_en_t1", axi_rd_en, 1'b1);
    check("d3_rd_addr_t1", axi_rd_addr, 20'h60804);
    check("d3_rvalid_t1", s_rvalid, 1'b0);
    @(negedge clk);
    check("d3_rd_en_t2", axi_rd_en, 1'b0);
    check("d3_rd_addr_t2", axi_rd_addr, 20'h60804);
    check("d3_rvalid_t2", s_rvalid, 1'b0);
    @(negedge clk);
    check("d3_rvalid_t3", s_rvalid, 1'b1);
    check("d3_rdata", s_rdata, 32'h1);
    check("d3_rresp", s_rresp, 2'b00);
    check("d3_rd_addr_t3", axi_rd_addr, 20'h60804);
    @(negedge clk);
    check("d3_rvalid_t4", s_rvalid, 1'b0);
    s_rready = 1'b0;
    $display("read  addr=0x60804 data=0x00000001 timing");

    // bready held low: second pair captured, not issued until first B accepted
    p0 = wr_pulses;
    s_awaddr = 20'h60810; s_awvalid = 1'b1; s_wdata = 32'h1111_2222; s_wstrb = 4'hF; s_wvalid = 1'b1;
    ref_write(20'h60810, 32'h1111_2222, 4'hF);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("d4_bvalid1", s_bvalid, 1'b1);
    s_awaddr = 20'h60814; s_awvalid = 1'b1; s_wdata = 32'h3333_4444; s_wstrb = 4'hF; s_wvalid = 1'b1;
    ref_write(20'h60814, 32'h3333_4444, 4'hF);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("d4_awready_full", s_awready, 1'b0);
    check("d4_wready_full", s_wready, 1'b0);
    repeat (10) @(negedge clk);
    check("d4_single_issue", wr_pulses - p0, 1);
    check("d4_bvalid_held", s_bvalid, 1'b1);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    repeat (3) @(negedge clk);
    check("d4_second_issue", wr_pulses - p0, 2);
    check("d4_wr_addr2", wr_last_addr, 20'h60814);
    check("d4_wr_data2", wr_last_data, 32'h3333_4444);
    check("d4_bvalid2", s_bvalid, 1'b1);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    $display("write addr=0x60810/0x60814 back-pressured pair");

    // reset asserted while in R_WAIT
    s_araddr = 20'h60820; s_arvalid = 1'b1; s_rready = 1'b0;
    @(negedge clk);
    s_arvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    p0 = rd_pulses;
    check("d5_rvalid_in_rst", s_rvalid, 1'b0);
    check("d5_rd_en_in_rst", axi_rd_en, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    repeat (5) @(negedge clk);
    check("d5_rvalid_after", s_rvalid, 1'b0);
    check("d5_arready_after", s_arready, 1'b1);
    check("d5_no_rd_en", rd_pulses - p0, 0);
    check("d5_awready_after", s_awready, 1'b1);
    check("d5_bvalid_after", s_bvalid, 1'b0);
    $display("reset during read wait");

    // out-of-range / misaligned accesses (SLVERR only when the feature is built in)
    do_write(20'h85C52, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    do_read(20'h85C54, 0, 1);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 2);
      wa = rand_addr();
      ra = rand_addr();
      while (ra[7:2] == wa[7:2]) ra = rand_addr();
      case (op)
        0: do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3));
        default: fork
          do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3));
        join
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
